// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: captures DW strobed bits after a start
// request and presents the finished word on out with a one-cycle valid pulse.
module sipo_deserializer #(
  parameter int DW        = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          enb,
  input  logic          sin,
  output logic [DW-1:0] out,
  output logic          valid,
  output logic          busy,
  output logic          err
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | capturing bits on enb strobes
  // DONE  | one cycle, new word on out, valid high

  localparam int              CW   = $clog2(DW + 1);
  localparam logic [CW-1:0]   LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] sr;
  logic [DW-1:0] sr_next;

  always_comb begin
    sr_next = sr;
    if (LSB_FIRST) sr_next = {sin, sr[DW-1:1]};
    else           sr_next = {sr[DW-2:0], sin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      out   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          // a strobe coinciding with start is deliberately not captured
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          err <= start;
          if (enb) begin
            sr <= sr_next;
            if (cnt == LAST) begin
              out   <= sr_next;
              state <= DONE;
              cnt   <= '0;
              valid <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one LSB-first and one MSB-first
// instance share the same stimulus and are checked against hand-derived words.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       enb;
  logic       sin;
  logic [7:0] out_l, out_m;
  logic       valid_l, valid_m, busy_l, busy_m, err_l, err_m;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.DW(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .enb(enb), .sin(sin),
    .out(out_l), .valid(valid_l), .busy(busy_l), .err(err_l)
  );

  sipo_deserializer #(.DW(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .start(start), .enb(enb), .sin(sin),
    .out(out_m), .valid(valid_m), .busy(busy_m), .err(err_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = w[7-k];
    return r;
  endfunction

  // inputs change at negedge, outputs sampled 1ns after the following posedge
  task automatic tick(input logic s, input logic e, input logic d);
    @(negedge clk);
    start = s;
    enb   = e;
    sin   = d;
    @(posedge clk);
    #1;
  endtask

  // sends w[0] first; optional enb=0 gaps and a start pulse on strobe err_at
  task automatic capture(input logic [7:0] w, input bit gaps, input int err_at,
                         input logic [7:0] prev_l, input logic [7:0] prev_m);
    logic [7:0] exp_m;
    exp_m = rev8(w);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          tick(1'b0, 1'b0, 1'b0);
          chk("gap_valid", {31'd0, valid_l | valid_m}, 32'd0);
          chk("gap_out_l", {24'd0, out_l}, {24'd0, prev_l});
          chk("gap_out_m", {24'd0, out_m}, {24'd0, prev_m});
        end
      end
      tick(i == err_at, 1'b1, w[i]);
      if (i == err_at) begin
        chk("err_pulse_l", {31'd0, err_l}, 32'd1);
        chk("err_pulse_m", {31'd0, err_m}, 32'd1);
      end else begin
        chk("err_quiet", {31'd0, err_l | err_m}, 32'd0);
      end
      if (i < 7) begin
        chk("part_valid", {31'd0, valid_l | valid_m}, 32'd0);
        chk("part_busy", {30'd0, busy_l, busy_m}, 32'd3);
        chk("part_out_l", {24'd0, out_l}, {24'd0, prev_l});
        chk("part_out_m", {24'd0, out_m}, {24'd0, prev_m});
      end else begin
        chk("done_valid", {30'd0, valid_l, valid_m}, 32'd3);
        chk("done_busy", {30'd0, busy_l, busy_m}, 32'd0);
        chk("done_out_l", {24'd0, out_l}, {24'd0, w});
        chk("done_out_m", {24'd0, out_m}, {24'd0, exp_m});
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    enb   = 1'b0;
    sin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {16'd0, out_l, out_m}, 32'd0);
    chk("rst_flags", {26'd0, valid_l, valid_m, busy_l, busy_m, err_l, err_m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // strobes while idle do nothing
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("idle_enb_busy", {30'd0, busy_l, busy_m}, 32'd0);
    chk("idle_enb_out", {16'd0, out_l, out_m}, 32'd0);

    // start together with a strobe: the 1 on sin must not be captured
    tick(1'b1, 1'b1, 1'b1);
    chk("start_busy", {30'd0, busy_l, busy_m}, 32'd3);
    chk("start_err", {31'd0, err_l | err_m}, 32'd0);
    capture(8'h4D, 1'b0, -1, 8'h00, 8'h00);
    tick(1'b0, 1'b0, 1'b0);
    chk("post_valid", {31'd0, valid_l | valid_m}, 32'd0);
    chk("post_busy", {30'd0, busy_l, busy_m}, 32'd0);
    chk("hold_out_l", {24'd0, out_l}, 32'h4D);
    chk("hold_out_m", {24'd0, out_m}, 32'hB2);

    // back-to-back: start accepted in DONE goes straight to SHIFT
    tick(1'b1, 1'b0, 1'b0);
    capture(8'h4D, 1'b0, -1, 8'h4D, 8'hB2);
    tick(1'b1, 1'b1, 1'b1);
    chk("b2b_busy", {30'd0, busy_l, busy_m}, 32'd3);
    chk("b2b_valid", {31'd0, valid_l | valid_m}, 32'd0);
    chk("b2b_err", {31'd0, err_l | err_m}, 32'd0);
    capture(8'h5A, 1'b0, -1, 8'h4D, 8'hB2);
    tick(1'b0, 1'b0, 1'b0);
    chk("b2b_end_busy", {30'd0, busy_l, busy_m}, 32'd0);

    // start during the 4th strobe is rejected with err
    tick(1'b1, 1'b0, 1'b0);
    capture(8'h4D, 1'b0, 3, 8'h5A, 8'h5A);
    tick(1'b0, 1'b0, 1'b0);

    // reset after 5 strobes discards the partial word
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      chk("pre_rst_valid", {31'd0, valid_l | valid_m}, 32'd0);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", {16'd0, out_l, out_m}, 32'd0);
    chk("async_rst_flags", {26'd0, valid_l, valid_m, busy_l, busy_m, err_l, err_m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
    chk("after_rst_idle", {30'd0, busy_l, busy_m}, 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    capture(8'hFF, 1'b0, -1, 8'h00, 8'h00);
    tick(1'b0, 1'b0, 1'b0);

    // strobes separated by 1-3 idle cycles; out holds FF meanwhile
    tick(1'b1, 1'b0, 1'b0);
    capture(8'h4D, 1'b1, -1, 8'hFF, 8'hFF);
    tick(1'b0, 1'b0, 1'b0);
    chk("final_valid", {31'd0, valid_l | valid_m}, 32'd0);
    chk("final_out", {16'd0, out_l, out_m}, 32'h4DB2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter DW, default 8 (value taken from package Global), meaning data word width in bits (DW >= 2).
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning 1 = first received bit lands in out[0]; 0 = first received bit lands in out[DW-1].
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, meaning request to begin capture of one word.
REQ-006 SHALL have port enb, input, 1 bit, meaning bit strobe; sin is sampled only on cycles where enb=1.
REQ-007 SHALL have port sin, input, 1 bit, meaning serial data in.
REQ-008 SHALL have port out, output, DW bits, meaning last completed word, held until the next completion.
REQ-009 SHALL have port valid, output, 1 bit, meaning one-cycle pulse marking a new word on out; intended to drive the enable of a downstream parallel register.
REQ-010 SHALL have port busy, output, 1 bit, meaning a capture is in progress.
REQ-011 SHALL have port err, output, 1 bit, meaning one-cycle pulse when start is rejected.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered or decoded from state only (no input-to-output combinational path).
REQ-013 IDLE: start=1 -> SHIFT, bit counter cleared to 0; otherwise stay in IDLE.
REQ-014 SHIFT: each enb=1 cycle shifts sin into the shift register and increments the counter; enb=0 cycles hold everything, with no timeout.
REQ-015 Shift direction: LSB_FIRST=1 -> sr <= {sin, sr[DW-1:1]}; LSB_FIRST=0 -> sr <= {sr[DW-2:0], sin}.
REQ-016 Counter width $clog2(DW+1); on the edge that samples the DW-th bit: out <= completed word, state -> DONE, counter -> 0.
REQ-017 DONE lasts exactly one cycle; valid=1 only in DONE; new out is visible in the same cycle as valid.
REQ-018 Latency: valid asserts on the cycle immediately after the cycle carrying the DW-th enb strobe.
REQ-019 DONE with start=1 -> SHIFT directly (back-to-back words, no IDLE cycle); DONE with start=0 -> IDLE.
REQ-020 busy=1 in SHIFT, 0 in IDLE and DONE.
REQ-021 start=1 while in SHIFT is ignored (capture continues unchanged) and err pulses for one cycle per such cycle.
REQ-022 enb=1 in IDLE or DONE has no effect on sr, counter, or out.
REQ-023 start and enb both 1 in IDLE: only the transition happens; that strobe's bit is not captured.
REQ-024 out changes only on word completion; a partial word never appears on out.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, counter=0, sr=0, out=0, valid=0, busy=0, err=0.
REQ-026 Reset mid-capture SHALL discard the partial word; out keeps reset value 0 and no valid is produced.
REQ-027 After rst deasserts, the first capture SHALL begin on the first start sampled high.

Verification (DW=8)
REQ-028 LSB_FIRST=1, start, then strobes with sin = 1,0,1,1,0,0,1,0 on consecutive cycles -> valid one cycle after 8th strobe, out=8'h4D, busy low with valid.
REQ-029 LSB_FIRST=0, same bit sequence -> out=8'hB2, single valid pulse.
REQ-030 Same as REQ-028 with enb=0 gaps of 1-3 cycles between strobes -> out=8'h4D; valid delayed by total gap cycles; out stable at its previous value throughout.
REQ-031 start pulsed in the 4th strobe cycle of a capture -> err pulse that cycle, capture unaffected, out=8'h4D.
REQ-032 rst asserted after 5 strobes, then a full word 8'hFF -> no valid before reset; out=0 until the new completion; then out=8'hFF.
REQ-033 start held high across DONE with two words 8'h4D then 8'h5A -> two valid pulses; no IDLE cycle between captures; out values in order.
